// File: rtl/fetch_sequencer.sv
// Byte-serial Y86 instruction fetch: sizes from byte 0, bounds-checks, assembles fields.
// Optional FETCH_PERF_EN adds instr_count/stall_cycles counters.
module fetch_sequencer #(
    parameter int MEM_DEPTH = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_load,
    input  logic [63:0] pc_in,
    output logic        mem_rd,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [1:0]  stat
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] instr_count,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_HALTED} state_t;

    localparam logic [1:0]  STAT_AOK = 2'd0;
    localparam logic [1:0]  STAT_HLT = 2'd1;
    localparam logic [1:0]  STAT_ADR = 2'd2;
    localparam logic [1:0]  STAT_INS = 2'd3;
    localparam logic [63:0] MAX_ADDR = 64'(MEM_DEPTH - 1);

    // Instruction length in bytes; 0 marks an invalid icode.
    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:             instr_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:       instr_len = 4'd2;
            4'h7, 4'h8:                   instr_len = 4'd9;
            4'h3, 4'h4, 4'h5:             instr_len = 4'd10;
            default:                      instr_len = 4'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [3:0]  k_q, k_d;
    logic        pend_q, pend_d;
    logic [3:0]  len_q, len_d;
    logic [1:0]  stat_q, stat_d;
    logic [7:0]  bytes_q [10];
    logic [7:0]  bytes_d [10];

    logic        issue;
    logic        rx0;
    logic [3:0]  len0;
    logic [3:0]  eff_len;
    logic [3:0]  cur_icode;
    logic [63:0] end_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            k_q     <= '0;
            pend_q  <= 1'b0;
            len_q   <= '0;
            stat_q  <= STAT_AOK;
            for (int i = 0; i < 10; i++) bytes_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            k_q     <= k_d;
            pend_q  <= pend_d;
            len_q   <= len_d;
            stat_q  <= stat_d;
            for (int i = 0; i < 10; i++) bytes_q[i] <= bytes_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        k_d     = k_q;
        pend_d  = pend_q;
        len_d   = len_q;
        stat_d  = stat_q;
        for (int i = 0; i < 10; i++) bytes_d[i] = bytes_q[i];
        issue   = 1'b0;

        // Byte 0 sizes the instruction in the same cycle it returns.
        rx0       = (state_q == S_FETCH) && pend_q && (k_q == 4'd1);
        len0      = instr_len(mem_rdata[7:4]);
        eff_len   = rx0 ? len0 : len_q;
        cur_icode = rx0 ? mem_rdata[7:4] : bytes_q[0][7:4];
        end_addr  = pc_q + 64'(len0) - 64'd1;

        if ((state_q == S_FETCH) && pend_q) begin
            for (int i = 0; i < 10; i++) begin
                if (k_q == 4'(i + 1)) bytes_d[i] = mem_rdata;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pc_load) begin
                    pc_d    = pc_in;
                    k_d     = '0;
                    pend_d  = 1'b0;
                    len_d   = '0;
                    stat_d  = STAT_AOK;
                    for (int i = 0; i < 10; i++) bytes_d[i] = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                pend_d = 1'b0;
                if (rx0) len_d = len0;
                if (k_q == 4'd0) begin
                    if (pc_q > MAX_ADDR) begin
                        stat_d  = STAT_ADR;
                        state_d = S_DONE;
                    end else begin
                        issue = 1'b1;
                    end
                end else if (rx0 && (len0 == 4'd0)) begin
                    stat_d  = STAT_INS;
                    state_d = S_DONE;
                end else if (rx0 && (end_addr > MAX_ADDR)) begin
                    stat_d  = STAT_ADR;
                    state_d = S_DONE;
                end else if (k_q < eff_len) begin
                    issue = 1'b1;
                end else begin
                    stat_d  = (cur_icode == 4'h0) ? STAT_HLT : STAT_AOK;
                    state_d = S_DONE;
                end
                if (issue) begin
                    pend_d = 1'b1;
                    k_d    = k_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = (stat_q != STAT_AOK) ? S_HALTED : S_IDLE;
            end
            default: state_d = S_HALTED;
        endcase
    end

    assign mem_rd    = issue;
    assign mem_addr  = issue ? (pc_q + 64'(k_q)) : 64'd0;
    assign out_valid = (state_q == S_DONE);

    logic [3:0]  ic;
    logic        need_regids;
    logic        need_valc;
    logic [63:0] valc_raw;

    always_comb begin
        ic          = bytes_q[0][7:4];
        need_regids = (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
        need_valc   = (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
        valc_raw    = '0;
        for (int j = 0; j < 8; j++) begin
            valc_raw[8*j +: 8] = need_regids ? bytes_q[j + 2] : bytes_q[j + 1];
        end
    end

    // Fields read as zero whenever nothing is being offered to decode.
    assign icode = out_valid ? ic : 4'h0;
    assign ifun  = out_valid ? bytes_q[0][3:0] : 4'h0;
    assign rA    = !out_valid ? 4'h0 : (need_regids ? bytes_q[1][7:4] : 4'hF);
    assign rB    = !out_valid ? 4'h0 : (need_regids ? bytes_q[1][3:0] : 4'hF);
    assign valC  = (out_valid && need_valc) ? valc_raw : 64'd0;
    assign valP  = !out_valid ? 64'd0 :
                   ((stat_q == STAT_ADR) || (stat_q == STAT_INS)) ? pc_q : (pc_q + 64'(len_q));
    assign stat  = out_valid ? stat_q : STAT_AOK;

`ifdef FETCH_PERF_EN
    logic [31:0] instr_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (out_valid && out_ready && ((stat_q == STAT_AOK) || (stat_q == STAT_HLT))
                && (instr_cnt_q != 32'hFFFF_FFFF))
                instr_cnt_q <= instr_cnt_q + 32'd1;
            if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign instr_count  = instr_cnt_q;
    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer with a latency-1 byte memory model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_load;
    logic [63:0] pc_in;
    logic        mem_rd;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [1:0]  stat;
`ifdef FETCH_PERF_EN
    logic [31:0] instr_count, stall_cycles;
`endif

    logic [7:0]  mem [0:2047];
    int          nvec = 0;
    int          nerr = 0;
    int          got_cyc, got_rds, addr_err;
    logic [63:0] first_addr, last_addr;

    always #5 clk = ~clk;

    fetch_sequencer #(.MEM_DEPTH(2048)) dut (
        .clk(clk), .rst(rst), .pc_load(pc_load), .pc_in(pc_in),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .stat(stat)
`ifdef FETCH_PERF_EN
        , .instr_count(instr_count), .stall_cycles(stall_cycles)
`endif
    );

    always @(posedge clk) begin
        if (mem_rd && (mem_addr < 64'd2048)) mem_rdata <= mem[mem_addr[10:0]];
        else mem_rdata <= 8'h00;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // pc_load is sampled at the end of cycle 0; sampling starts mid cycle 1.
    task automatic run_fetch(input logic [63:0] p);
        bit done;
        done = 0;
        got_cyc = 0; got_rds = 0; addr_err = 0;
        first_addr = '1; last_addr = '1;
        @(negedge clk);
        pc_load = 1'b1;
        pc_in   = p;
        @(negedge clk);
        pc_load = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            if (mem_rd) begin
                if (got_rds == 0) first_addr = mem_addr;
                else if (mem_addr != last_addr + 64'd1) addr_err++;
                last_addr = mem_addr;
                got_rds++;
            end
            if (out_valid) begin
                got_cyc = c;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_accept_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[0] = 8'h10;
        mem[12'h100] = 8'h30; mem[12'h101] = 8'hF3; mem[12'h102] = 8'hEF; mem[12'h103] = 8'hCD;
        mem[12'h104] = 8'hAB; mem[12'h105] = 8'h89; mem[12'h106] = 8'h67; mem[12'h107] = 8'h45;
        mem[12'h108] = 8'h23; mem[12'h109] = 8'h01;
        mem[2046] = 8'h30;
        mem[12'h200] = 8'h20; mem[12'h201] = 8'h12;
        mem[12'h300] = 8'h00;

        rst = 1'b1; pc_load = 1'b0; pc_in = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mem_rd",    64'(mem_rd),    64'd0);
        chk("rst_mem_addr",  mem_addr,       64'd0);
        chk("rst_valC",      valC,           64'd0);
        chk("rst_valP",      valP,           64'd0);
        chk("rst_stat",      64'(stat),      64'd0);
        rst = 1'b0;

        // One-byte instruction at 0
        run_fetch(64'd0);
        chk("nop_cycle", 64'(got_cyc), 64'd3);
        chk("nop_reads", 64'(got_rds), 64'd1);
        chk("nop_icode", 64'(icode),   64'h1);
        chk("nop_ifun",  64'(ifun),    64'h0);
        chk("nop_rA",    64'(rA),      64'hF);
        chk("nop_rB",    64'(rB),      64'hF);
        chk("nop_valC",  valC,         64'd0);
        chk("nop_valP",  valP,         64'd1);
        chk("nop_stat",  64'(stat),    64'd0);
        accept();

        // irmovq at 0x100
        run_fetch(64'h100);
        chk("irm_cycle", 64'(got_cyc), 64'd12);
        chk("irm_reads", 64'(got_rds), 64'd10);
        chk("irm_first", first_addr,   64'h100);
        chk("irm_last",  last_addr,    64'h109);
        chk("irm_seq",   64'(addr_err), 64'd0);
        chk("irm_icode", 64'(icode),   64'h3);
        chk("irm_rA",    64'(rA),      64'hF);
        chk("irm_rB",    64'(rB),      64'h3);
        chk("irm_valC",  valC,         64'h0123456789ABCDEF);
        chk("irm_valP",  valP,         64'h10A);
        chk("irm_stat",  64'(stat),    64'd0);
        accept();

        // Instruction running past the end of memory, then HALTED ignores pc_load
        run_fetch(64'd2046);
        chk("adr_rng_cycle", 64'(got_cyc), 64'd3);
        chk("adr_rng_reads", 64'(got_rds), 64'd1);
        chk("adr_rng_stat",  64'(stat),    64'd2);
        chk("adr_rng_valP",  valP,         64'd2046);
        accept();
        @(negedge clk);
        pc_load = 1'b1; pc_in = 64'd0;
        got_rds = 0; got_cyc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            pc_load = 1'b0;
            if (mem_rd) got_rds++;
            if (out_valid) got_cyc++;
        end
        chk("halted_reads", 64'(got_rds), 64'd0);
        chk("halted_valid", 64'(got_cyc), 64'd0);
        do_reset();

        // Invalid icode
        mem[0] = 8'hC0;
        run_fetch(64'd0);
        chk("ins_cycle", 64'(got_cyc), 64'd3);
        chk("ins_reads", 64'(got_rds), 64'd1);
        chk("ins_stat",  64'(stat),    64'd3);
        chk("ins_icode", 64'(icode),   64'hC);
        chk("ins_valP",  valP,         64'd0);
        accept();
        do_reset();

        // PC outside memory
        run_fetch(64'd4096);
        chk("adr_pc_cycle", 64'(got_cyc), 64'd2);
        chk("adr_pc_reads", 64'(got_rds), 64'd0);
        chk("adr_pc_stat",  64'(stat),    64'd2);
        chk("adr_pc_valP",  valP,         64'd4096);
        accept();
        do_reset();

        // rrmovq with decode stalling for 5 cycles
        run_fetch(64'h200);
        chk("rr_cycle", 64'(got_cyc), 64'd4);
        for (int s = 0; s < 5; s++) begin
            chk("rr_hold_valid", 64'(out_valid), 64'd1);
            chk("rr_hold_fields", {48'd0, icode, ifun, rA, rB}, 64'h2012);
            chk("rr_hold_valP", valP, 64'h202);
            @(negedge clk);
        end
        chk("rr_valC", valC, 64'd0);
        accept();
`ifdef FETCH_PERF_EN
        chk("perf_stall", 64'(stall_cycles), 64'd5);
        chk("perf_instr", 64'(instr_count),  64'd1);
`endif

        // halt instruction returns to HALTED after accept
        run_fetch(64'h300);
        chk("hlt_cycle", 64'(got_cyc), 64'd3);
        chk("hlt_stat",  64'(stat),    64'd1);
        chk("hlt_valP",  valP,         64'h301);
        accept();
        do_reset();

        // Reset asserted in cycle 5 of an irmovq fetch
        @(negedge clk);
        pc_load = 1'b1; pc_in = 64'h100;
        @(negedge clk);
        pc_load = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_mem_rd", 64'(mem_rd), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_mem_rd",   64'(mem_rd),    64'd0);
        chk("mid_rst_valid",    64'(out_valid), 64'd0);
        chk("mid_rst_mem_addr", mem_addr,       64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_fetch(64'h100);
        chk("re_cycle", 64'(got_cyc), 64'd12);
        chk("re_valC",  valC,         64'h0123456789ABCDEF);
        chk("re_valP",  valP,         64'h10A);
        accept();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction fetch controller for the Y86 SEQ core. Given a new PC, it reads instruction bytes one per cycle from a byte-wide synchronous instruction memory port. It sizes the fetch from the first byte, assembles icode/ifun/rA/rB/valC/valP and fetch status, and hands the result to decode over a valid/ready handshake. It replaces the flat 10-byte combinational read with a sequenced, bounds-checked fetch.

## Interface
- MEM_DEPTH, 2048: instruction memory size in bytes; legal addresses 0..MEM_DEPTH-1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- pc_load  in  1  start fetch at pc_in (sampled in IDLE only)
- pc_in  in  64  fetch address
- mem_rd  out  1  byte read request
- mem_addr  out  64  byte address for mem_rd
- mem_rdata  in  8  read data, valid the cycle after mem_rd (latency 1)
- out_valid  out  1  decoded instruction available
- out_ready  in  1  decode accepts
- icode, ifun, rA, rB  out  4 each  instruction fields
- valC  out  64  constant word, little-endian assembled
- valP  out  64  pc + instruction length
- stat  out  2  0 AOK, 1 HLT, 2 ADR, 3 INS

## Operation
- States: IDLE, FETCH, DONE, HALTED.
- IDLE: on pc_load, latch pc, clear byte count k, go to FETCH.
- FETCH:
  - Issue mem_rd with mem_addr=pc+k for k=0..L-1, one per cycle.
  - Capture mem_rdata into byte slot k the cycle after issue.
- Length L comes from byte 0's icode, computed combinationally from mem_rdata in the cycle byte 0 returns:
  - 0,1,9 -> 1
  - 2,6,A,B -> 2
  - 7,8 -> 9
  - 3,4,5 -> 10
  - C..F -> invalid
- need_regids for icode 2,3,4,5,6,A,B.
  - rA/rB = byte1[7:4]/[3:0]; otherwise both are 0xF.
- valC = bytes (1+need_regids)..(8+need_regids); the lowest-address byte is the LSB. valC = 0 if not needed.
- Error handling:
  - If pc > MEM_DEPTH-1: issue nothing; stat=ADR; go to DONE.
  - If pc+L-1 > MEM_DEPTH-1 (checked when byte 0 returns): no further issues; stat=ADR; go to DONE.
  - Invalid icode: no further issues; stat=INS; go to DONE.
- icode 0: stat=HLT.
- DONE:
  - out_valid=1; all outputs are held stable until out_ready.
  - On out_valid&&out_ready: go to HALTED if stat≠AOK, else IDLE.
- HALTED: ignore pc_load until rst.
- pc_load outside IDLE is ignored.
- valP = pc+L, 64-bit, wraps modulo 2^64. On ADR/INS, valP = pc.

## Timing
- Reset: all outputs are 0, including mem_rd, mem_addr, out_valid, valC, valP and stat (AOK). State is IDLE.
- For pc_load in cycle 0:
  - Reads are issued in cycles 1..L.
  - Data returns in cycles 2..L+1.
  - out_valid rises in cycle L+2.
  - Example: nop -> 3 cycles; irmovq -> 12 cycles.
- ADR on pc: out_valid in cycle 2, mem_rd never asserted.
- ADR on range, or INS: out_valid in cycle 3, exactly one read issued.
- With out_ready held high, the minimum IDLE re-entry is the cycle after acceptance.
- rst mid-fetch (any state):
  - Immediate return to IDLE with mem_rd=0 and outputs zeroed.
  - A late mem_rdata is ignored.

## Configuration
- FETCH_PERF_EN defined:
  - Adds outputs instr_count[31:0] (increments on each accepted AOK/HLT instruction) and stall_cycles[31:0] (increments each cycle out_valid&&!out_ready).
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Memory 0x10 at address 0; pc_load pc_in=0 -> one read; out_valid in cycle 3; icode=1, ifun=0, rA=rB=F, valC=0, valP=1, stat=0.
- irmovq 30 F3 EF CD AB 89 67 45 23 01 at 0x100 -> reads 0x100..0x109; out_valid in cycle 12; rB=3, valC=0x0123456789ABCDEF, valP=0x10A.
- Byte 0x30 at address 2046 -> stat=2 (ADR) in cycle 3, valP=2046; after accept, HALTED; a subsequent pc_load produces no mem_rd.
- Byte 0xC0 at 0 -> stat=3 (INS), icode=0xC; pc_in=4096 -> stat=2, no mem_rd, out_valid in cycle 2.
- rrmovq 20 12 with out_ready low for 5 cycles -> outputs stable; accept in cycle 9; with FETCH_PERF_EN, stall_cycles=5 and instr_count=1.
- Assert rst in cycle 5 of an irmovq fetch -> mem_rd=0 and out_valid=0 from reset; a fresh pc_load then fetches correctly.
